// File: rtl/regfile_mp_sb_pkg.sv
// Shared core definitions: register file geometry and
// scoreboard counter types.
package cpuDefine;

  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PEND_WIDTH = 2;
  localparam int ADDR_W     = $clog2(REG_NUM);

  typedef logic [DATA_WIDTH-1:0] DType;
  typedef DType                  Gr [REG_NUM];
  typedef logic [ADDR_W-1:0]     RegAddr;
  typedef logic [PEND_WIDTH-1:0] PendCnt;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: per-register counters,
// allocate back-pressure, sticky underflow and busy flags.
module regfile_scoreboard
  import cpuDefine::*;
#(
  parameter int NUM_REGS  = REG_NUM,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int PEND_W    = PEND_WIDTH,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_ALLOC-1:0]           alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0]   alloc_addr,
  output logic                           alloc_ready,
  input  logic                           flush,
  output logic                           pend_err
);

  localparam int CW = PEND_W + 2;
  localparam logic [CW-1:0] MAX = CW'((1 << PEND_W) - 1);

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic [CW-1:0]     inc    [NUM_REGS];
  logic [CW-1:0]     dec    [NUM_REGS];
  logic [CW-1:0]     tot    [NUM_REGS];
  logic              pend_err_q;
  logic              pend_err_d;

  always_comb begin
    for (int a = 0; a < NUM_REGS; a++) begin
      inc[a] = '0;
      dec[a] = '0;
      if (a != 0) begin
        for (int p = 0; p < NUM_ALLOC; p++)
          if (alloc_en[p] && alloc_addr[p] == AW'(a))
            inc[a] = inc[a] + CW'(1);
        for (int w = 0; w < NUM_WR; w++)
          if (wr_en[w] && wr_addr[w] == AW'(a))
            dec[a] = dec[a] + CW'(1);
      end
    end
  end

  // pend + inc - dec > MAX, rearranged to stay unsigned
  always_comb begin
    alloc_ready = 1'b1;
    for (int a = 1; a < NUM_REGS; a++)
      if (CW'(pend_q[a]) + inc[a] > dec[a] + MAX)
        alloc_ready = 1'b0;
  end

  always_comb begin
    pend_err_d = pend_err_q;
    for (int a = 0; a < NUM_REGS; a++) begin
      tot[a]    = CW'(pend_q[a]);
      pend_d[a] = '0;
      if (alloc_ready)
        tot[a] = tot[a] + inc[a];
      if (a == 0 || flush) begin
        pend_d[a] = '0;
      end else if (tot[a] < dec[a]) begin
        pend_d[a]  = '0;
        pend_err_d = 1'b1;
      end else begin
        pend_d[a] = PEND_W'(tot[a] - dec[a]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = 1'b0;
      if (rd_addr[i] != '0) begin
        if (BYPASS != 0)
          rd_busy[i] = CW'(pend_q[rd_addr[i]]) > dec[rd_addr[i]];
        else
          rd_busy[i] = pend_q[rd_addr[i]] != '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_REGS; a++)
        pend_q[a] <= '0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end

  assign pend_err = pend_err_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with prioritised writes,
// optional write-to-read bypass and pending-write scoreboard.
module regfile_mp_sb
  import cpuDefine::*;
#(
  parameter int NUM_REGS  = REG_NUM,
  parameter int DATA_W    = DATA_WIDTH,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int PEND_W    = PEND_WIDTH,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_ALLOC-1:0]           alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0]   alloc_addr,
  output logic                           alloc_ready,
  input  logic                           flush,
  output logic                           pend_err
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // ascending port loop: last match (highest index) wins
  always_comb begin
    mem_d = mem_q;
    for (int a = 1; a < NUM_REGS; a++)
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_addr[w] == AW'(a))
          mem_d[a] = wr_data[w];
    mem_d[0] = '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int a = 0; a < NUM_REGS; a++)
        mem_q[a] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i] = mem_q[rd_addr[i]];
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WR; w++)
          if (wr_en[w] && wr_addr[w] == rd_addr[i])
            rd_data[i] = wr_data[w];
      if (rd_addr[i] == '0)
        rd_data[i] = '0;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .PEND_W    (PEND_W),
    .BYPASS    (BYPASS)
  ) u_sb (
    .clk         (aclk),
    .rst         (areset),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .flush       (flush),
    .pend_err    (pend_err)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus random
// traffic against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int NR  = 32;
  localparam int DW  = 32;
  localparam int NRD = 6;
  localparam int NWR = 2;
  localparam int NAL = 2;
  localparam int AW  = 5;
  localparam int PMAX = 3;

  logic                      aclk;
  logic                      areset;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][DW-1:0]    rd_data;
  logic [NRD-1:0]            rd_busy;
  logic [NWR-1:0]            wr_en;
  logic [NWR-1:0][AW-1:0]    wr_addr;
  logic [NWR-1:0][DW-1:0]    wr_data;
  logic [NAL-1:0]            alloc_en;
  logic [NAL-1:0][AW-1:0]    alloc_addr;
  logic                      alloc_ready;
  logic                      flush;
  logic                      pend_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [NR];
  int            m_pend [NR];
  bit            m_err;

  regfile_mp_sb dut (
    .aclk        (aclk),
    .areset      (areset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .flush       (flush),
    .pend_err    (pend_err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic int cnt_wr(int a);
    int n = 0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_addr[w]) == a) n++;
    return n;
  endfunction

  function automatic int cnt_alloc(int a);
    int n = 0;
    for (int p = 0; p < NAL; p++)
      if (alloc_en[p] && int'(alloc_addr[p]) == a) n++;
    return n;
  endfunction

  function automatic bit exp_ready();
    for (int a = 1; a < NR; a++)
      if (m_pend[a] + cnt_alloc(a) - cnt_wr(a) > PMAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int i);
    int a = int'(rd_addr[i]);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_addr[w]) == a) v = wr_data[w];
    return v;
  endfunction

  function automatic bit exp_busy(int i);
    int a = int'(rd_addr[i]);
    if (a == 0) return 1'b0;
    return (m_pend[a] - cnt_wr(a)) > 0;
  endfunction

  task automatic clear_inputs();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = '0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  // advance model by one clock using the current inputs
  task automatic tick();
    bit rdy;
    int n;
    rdy = exp_ready();
    if (areset) begin
      for (int a = 0; a < NR; a++) begin
        m_reg[a]  = '0;
        m_pend[a] = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int a = 1; a < NR; a++) begin
        n = m_pend[a] + (rdy ? cnt_alloc(a) : 0) - cnt_wr(a);
        if (flush) m_pend[a] = 0;
        else if (n < 0) begin
          m_pend[a] = 0;
          m_err = 1'b1;
        end else m_pend[a] = n;
      end
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w] != '0)
          m_reg[wr_addr[w]] = wr_data[w];
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NRD; i++) rd_addr[i] = AW'(i + 1);
    #1;
    for (int i = 0; i < NRD; i++) begin
      checks++;
      if (rd_data[i] !== '0 || rd_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd%0d data=%h busy=%b want 0/0", i, rd_data[i], rd_busy[i]);
      end
    end
    checks++;
    if (alloc_ready !== 1'b1 || pend_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ready=%b err=%b want 1/0", alloc_ready, pend_err);
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    rd_addr[0] = 5;
    wr_en = 2'b11;
    wr_addr[0] = 5;
    wr_addr[1] = 5;
    wr_data[0] = 32'h1111_0000;
    wr_data[1] = 32'hAAAA_0000;
    #1;
    checks++;
    if (rd_data[0] !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL prio_bypass got=%h want=AAAA0000", rd_data[0]);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rd_data[0] !== 32'hAAAA_0000) begin
        errors++;
        $display("FAIL prio_stored c=%0d got=%h want=AAAA0000", c, rd_data[0]);
      end
      tick();
    end
  endtask

  task automatic test_r0();
    do_reset();
    rd_addr[0] = 0;
    rd_addr[1] = 0;
    wr_en[1] = 1'b1;
    wr_addr[1] = 0;
    wr_data[1] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rd_data[0] !== '0) begin
      errors++;
      $display("FAIL r0_bypass got=%h want=0", rd_data[0]);
    end
    tick();
    clear_inputs();
    alloc_en = 2'b11;
    #1;
    checks++;
    if (rd_data[1] !== '0) begin
      errors++;
      $display("FAIL r0_read got=%h want=0", rd_data[1]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || pend_err !== 1'b0 || alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_alloc busy=%b err=%b ready=%b want 0/0/1",
               rd_busy[0], pend_err, alloc_ready);
    end
  endtask

  task automatic test_alloc_saturate();
    logic [2:0] want_busy;
    do_reset();
    rd_addr[0] = 7;
    alloc_en = 2'b11;
    alloc_addr[0] = 7;
    alloc_addr[1] = 7;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_first ready=%b busy=%b want 1/0", alloc_ready, rd_busy[0]);
    end
    tick();
    #1;
    checks++;
    if (alloc_ready !== 1'b0 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_reject ready=%b busy=%b want 0/1", alloc_ready, rd_busy[0]);
    end
    tick();
    alloc_en = 2'b01;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_third ready=%b want 1", alloc_ready);
    end
    tick();
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_full ready=%b want 0", alloc_ready);
    end
    clear_inputs();
    want_busy = 3'b011;
    for (int k = 0; k < 3; k++) begin
      wr_en = 2'b01;
      wr_addr[0] = 7;
      wr_data[0] = 32'h700 + k;
      #1;
      checks++;
      if (rd_busy[0] !== want_busy[k]) begin
        errors++;
        $display("FAIL sat_wb%0d busy=%b want=%b", k, rd_busy[0], want_busy[k]);
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || pend_err !== 1'b0 || rd_data[0] !== 32'h702) begin
      errors++;
      $display("FAIL sat_done busy=%b err=%b data=%h want 0/0/702",
               rd_busy[0], pend_err, rd_data[0]);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_addr[0] = 9;
    wr_en = 2'b01;
    wr_addr[0] = 9;
    wr_data[0] = 32'h1234_5678;
    tick();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pend_err !== 1'b1 || rd_data[0] !== 32'h1234_5678 || rd_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL uflow c=%0d err=%b data=%h busy=%b want 1/12345678/0",
                 c, pend_err, rd_data[0], rd_busy[0]);
      end
      tick();
    end
    do_reset();
    #1;
    checks++;
    if (pend_err !== 1'b0) begin
      errors++;
      $display("FAIL uflow_clear err=%b want 0", pend_err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    rd_addr[0] = 3;
    alloc_en = 2'b11;
    alloc_addr[0] = 3;
    alloc_addr[1] = 3;
    tick();
    clear_inputs();
    flush = 1'b1;
    alloc_en = 2'b01;
    alloc_addr[0] = 3;
    wr_en = 2'b01;
    wr_addr[0] = 3;
    wr_data[0] = 32'h55;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h55 || pend_err !== 1'b0) begin
      errors++;
      $display("FAIL flush busy=%b data=%h err=%b want 0/55/0",
               rd_busy[0], rd_data[0], pend_err);
    end
    wr_en = 2'b11;
    wr_addr[0] = 10;
    wr_addr[1] = 3;
    wr_data[0] = 32'hABCD;
    wr_data[1] = 32'hBEEF;
    tick();
    areset = 1'b1;
    wr_data[0] = 32'h9999;
    alloc_en = 2'b01;
    alloc_addr[0] = 10;
    tick();
    areset = 1'b0;
    clear_inputs();
    rd_addr[0] = 3;
    rd_addr[1] = 10;
    #1;
    checks++;
    if (rd_data[0] !== '0 || rd_data[1] !== '0 || rd_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset r3=%h r10=%h busy=%b want 0/0/0",
               rd_data[0], rd_data[1], rd_busy[1]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 3) == 0);
        wr_addr[w] = AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      for (int p = 0; p < NAL; p++) begin
        alloc_en[p]   = $urandom_range(0, 1) == 1;
        alloc_addr[p] = AW'($urandom_range(0, 7));
      end
      flush  = ($urandom_range(0, 15) == 0);
      areset = ($urandom_range(0, 63) == 0);
      #1;
      for (int i = 0; i < NRD; i++) begin
        ed = exp_rd(i);
        checks++;
        if (rd_data[i] !== ed || rd_busy[i] !== exp_busy(i)) begin
          errors++;
          $display("FAIL rand c=%0d rd%0d a=%0d data=%h busy=%b want %h/%b",
                   c, i, rd_addr[i], rd_data[i], rd_busy[i], ed, exp_busy(i));
        end
      end
      checks++;
      if (alloc_ready !== exp_ready() || pend_err !== m_err) begin
        errors++;
        $display("FAIL rand c=%0d ready=%b err=%b want %b/%b",
                 c, alloc_ready, pend_err, exp_ready(), m_err);
      end
      tick();
    end
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b0;
    rd_addr = '0;
    clear_inputs();
    test_reset();
    test_write_priority();
    test_r0();
    test_alloc_saturate();
    test_underflow();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
